mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/common.sv | 24 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// rtl/common.sv - shared memory access and arbiter type definitions
package common;

  // Access width code carried on *_wstrb
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_access_type;

  // Arbiter control state; one transaction outstanding at most
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } arb_state;

  // Which requester owns the outstanding transaction
  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single shared memory port
module mem_arbiter
  import common::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_wstrb,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state             state_q;
  arb_owner             owner_q;
  logic [STREAK_W-1:0]  streak_q;
  logic [STREAK_W-1:0]  streak_d;
  logic [31:0]          addr_q;
  logic                 we_q;
  logic [31:0]          wdata_q;
  logic [1:0]           wstrb_q;
  logic                 if_rvalid_q;
  logic                 d_rvalid_q;
  logic [31:0]          if_rdata_q;
  logic [31:0]          d_rdata_q;

  logic                 grant_data;
  logic                 grant_if;

  // Pick the winner in IDLE: data by default, fetch once data has won MAX_DATA_STREAK times in a row
  always_comb begin
    grant_data = 1'b0;
    grant_if   = 1'b0;
    streak_d   = streak_q;
    if (state_q == IDLE) begin
      if (d_req && (!if_req || (streak_q != STREAK_MAX))) begin
        grant_data = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end

      if (grant_data) begin
        if (!if_req) begin
          streak_d = '0;
        end else if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else if (grant_if) begin
        streak_d = '0;
      end
    end
  end

  // Arbiter FSM: latch the winner's request, hold it on the memory port until granted, route the response back
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      streak_q    <= streak_d;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            owner_q <= OWN_DATA;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            wstrb_q <= d_wstrb;
            state_q <= ISSUE;
          end else if (grant_if) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= MEM_WORD;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner_q == OWN_DATA) begin
              d_rdata_q  <= mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Acceptance is decided in the IDLE cycle itself so a response cycle can also start the next transaction
  assign if_ready  = grant_if;
  assign d_ready   = grant_data;

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  byte         glog[$];
  int          gcyc_log[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  bit          mon_en      = 0;
  bit          hold_if     = 0;
  bit          hold_d      = 0;
  bit          manual      = 0;
  bit          spurious    = 0;
  bit          rsp_pend    = 0;
  logic [31:0] rsp_data    = '0;
  int          gnt_stall_cfg = 0;
  int          stall_cnt   = 0;
  int          rv_d_cyc    = -1;
  logic [31:0] last_if     = '0;
  logic [31:0] last_d      = '0;
  bit          got_if;
  bit          got_d;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0010_0073;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory port model: grant after a configurable stall, respond one cycle after the grant
  task automatic mem_drive();
    if (manual) return;
    mem_rvalid = rsp_pend;
    mem_rdata  = rsp_pend ? rsp_data : 32'h0BAD_0BAD;
    rsp_pend   = 0;
    mem_gnt    = 1'b0;
    if (spurious) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      mem_gnt    = 1'b1;
    end else if (mem_req === 1'b1) begin
      if (stall_cnt > 0) begin
        stall_cnt--;
      end else begin
        mem_gnt  = 1'b1;
        rsp_pend = 1;
        rsp_data = memval(mem_addr);
      end
    end
  endtask

  task automatic sample_ready();
    exp_t e;
    got_if = 0;
    got_d  = 0;
    if (!mon_en) return;
    chk("ready_onehot", 32'(if_ready && d_ready), 32'd0);
    if (d_ready === 1'b1) begin
      got_d = 1;
      e.is_data = 1; e.data = memval(d_addr); e.gcyc = cyc; e.lat = 3 + gnt_stall_cfg;
      sb.push_back(e);
      glog.push_back("D");
      gcyc_log.push_back(cyc);
      stall_cnt = gnt_stall_cfg;
    end else if (if_ready === 1'b1) begin
      got_if = 1;
      e.is_data = 0; e.data = memval(if_addr); e.gcyc = cyc; e.lat = 3 + gnt_stall_cfg;
      sb.push_back(e);
      glog.push_back("I");
      gcyc_log.push_back(cyc);
      stall_cnt = gnt_stall_cfg;
    end
  endtask

  task automatic check_rvalid();
    exp_t e;
    if (!mon_en) return;
    chk("rvalid_onehot", 32'(if_rvalid && d_rvalid), 32'd0);
    if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_owner", 32'(d_rvalid), 32'(e.is_data));
        chk("rdata", e.is_data ? d_rdata : if_rdata, e.data);
        chk("latency", 32'(cyc - e.gcyc), 32'(e.lat));
        if (e.is_data) begin
          last_d   = e.data;
          rv_d_cyc = cyc;
        end else begin
          last_if = e.data;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    sample_ready();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (got_if && !hold_if) if_req = 1'b0;
    if (got_d && !hold_d) d_req = 1'b0;
    mem_drive();
    #1;
    check_rvalid();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || if_req || d_req) && n < 60) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < 60), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string exp_order = "DDDDIDDDDI";
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 2'b10;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clock);
    step();
    step();
    reset = 1'b0;
    mon_en = 1;

    // reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);

    // fetch only, minimum latency
    if_req = 1'b1; if_addr = 32'h0000_0100;
    step();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h0000_0100);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    chk("f_mem_wstrb", 32'(mem_wstrb), 32'd2);
    chk("f_busy", 32'(busy), 32'd1);
    drain();
    chk("f_if_rdata", if_rdata, 32'h0010_0073);
    chk("f_busy_after", 32'(busy), 32'd0);

    // simultaneous fetch and load: data first, fetch granted in the data response cycle
    glog.delete(); gcyc_log.delete();
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_wstrb = 2'b10;
    drain();
    chk("both_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("both_first", 32'(glog[0]), 32'("D"));
      chk("both_second", 32'(glog[1]), 32'("I"));
      chk("both_period", 32'(gcyc_log[1] - gcyc_log[0]), 32'd3);
      chk("both_same_idle", 32'(gcyc_log[1]), 32'(rv_d_cyc));
    end

    // continuous contention: streak limit
    glog.delete(); gcyc_log.delete();
    hold_if = 1; hold_d = 1;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_req = 1'b1; d_addr = 32'h0000_2400;
    begin
      int n = 0;
      while (glog.size() < 10 && n < 60) begin
        step();
        n++;
      end
      chk("streak_bound", 32'(n < 60), 32'd1);
    end
    hold_if = 0; hold_d = 0; if_req = 1'b0; d_req = 1'b0;
    drain();
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
      byte c;
      c = exp_order[i];
      chk($sformatf("streak_order_%0d", i), 32'(glog[i]), 32'(c));
    end

    // grant held off for 5 cycles
    gnt_stall_cfg = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_req_%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("stall_addr_%0d", i), mem_addr, 32'h0000_3000);
      chk($sformatf("stall_busy_%0d", i), 32'(busy), 32'd1);
      chk($sformatf("stall_gnt_%0d", i), 32'(mem_gnt), 32'd0);
      step();
    end
    drain();
    gnt_stall_cfg = 0;

    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF; d_wstrb = 2'b10;
    step();
    chk("st_mem_req", 32'(mem_req), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", mem_addr, 32'h0000_0040);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_wstrb", 32'(mem_wstrb), 32'd2);
    drain();
    chk("st_d_rdata", d_rdata, memval(32'h0000_0040));
    d_we = 1'b0;

    // stray grant and response while idle are ignored
    spurious = 1;
    step();
    spurious = 0;
    step();
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_if_rdata", if_rdata, last_if);
    chk("spur_d_rdata", d_rdata, last_d);

    // reset while waiting for a response, late response dropped
    manual = 1; rsp_pend = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_5000;
    step();
    chk("rw_issue", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rw_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    last_if = '0; last_d = '0;
    chk("rw_busy_rst", 32'(busy), 32'd0);
    chk("rw_mem_req_rst", 32'(mem_req), 32'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("rw_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rw_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_d_rdata", d_rdata, 32'd0);
    chk("rw_if_rdata", if_rdata, 32'd0);
    manual = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
